// File: rtl/uart_cmd_pkg.sv
// Shared definitions for the UART command decoder: sync byte, FSM encoding
// and the frame checksum helper (also usable by host-side models).
package uart_cmd_pkg;

   localparam logic [7:0] SYNC_BYTE = 8'hA5;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_ADDR  = 3'd1,
      ST_DATA  = 3'd2,
      ST_CHK   = 3'd3,
      ST_WRITE = 3'd4
   } state_t;

   // Data is zero-extended to 32 bits by the caller; zero bytes do not alter the XOR.
   function automatic logic [7:0] cmd_xor(input logic [7:0] addr, input logic [31:0] data);
      cmd_xor = addr ^ data[31:24] ^ data[23:16] ^ data[15:8] ^ data[7:0];
   endfunction

endpackage

// File: rtl/uart_cmd_decoder_byte_edge.sv
// Rising-edge detector on the receiver done flag: one byte strobe per edge.
// done_q resets high so a flag already high across reset is not a new byte.
module byte_edge_detect (
   input  logic clk,
   input  logic rst,
   input  logic din_done,
   output logic byte_stb
);

   logic done_q_r;

   // Previous-cycle copy of the done flag.
   always_ff @(posedge clk) begin
      if (rst) begin
         done_q_r <= 1'b1;
      end else begin
         done_q_r <= din_done;
      end
   end

   assign byte_stb = din_done & ~done_q_r;

endmodule

// File: rtl/uart_cmd_decoder.sv
// Framed register-write command decoder: SYNC, ADDR, data bytes MSB first,
// optional XOR checksum byte when UART_CMD_CHECKSUM_EN is defined.
module uart_cmd_decoder
   import uart_cmd_pkg::*;
#(
   parameter int DATA_BYTES     = 2,
   parameter int TIMEOUT_CYCLES = 4096
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [7:0]              din,
   input  logic                    din_done,
   output logic                    wr_en,
   output logic [7:0]              wr_addr,
   output logic [8*DATA_BYTES-1:0] wr_data,
   output logic                    frame_err,
   output logic                    busy
);

   localparam int              DW        = 8 * DATA_BYTES;
   localparam int              TW        = $clog2(TIMEOUT_CYCLES);
   localparam logic [TW-1:0]   TMO_LAST  = TW'(TIMEOUT_CYCLES - 1);
   localparam logic [2:0]      LAST_BYTE = 3'(DATA_BYTES - 1);

   logic              byte_stb_s;
   state_t            state_r, state_s;
   logic [7:0]        addr_sh_r, addr_sh_s;
   logic [DW-1:0]     data_sh_r, data_sh_s;
   logic [2:0]        byte_cnt_r, byte_cnt_s;
   logic [TW-1:0]     tmo_cnt_r, tmo_cnt_s;
   logic              tmo_hit_s;
   logic              wr_en_s, frame_err_s, busy_s;
   logic [7:0]        wr_addr_s;
   logic [DW-1:0]     wr_data_s;

   byte_edge_detect u_edge (
      .clk      (clk),
      .rst      (rst),
      .din_done (din_done),
      .byte_stb (byte_stb_s)
   );

   // Next-state, shadow, timeout and registered-output computation.
   always_comb begin
      state_s     = state_r;
      addr_sh_s   = addr_sh_r;
      data_sh_s   = data_sh_r;
      byte_cnt_s  = byte_cnt_r;
      frame_err_s = 1'b0;
      tmo_hit_s   = (state_r != ST_IDLE) && (state_r != ST_WRITE) && (tmo_cnt_r == TMO_LAST);

      case (state_r)
         ST_IDLE: begin
            if (byte_stb_s && (din == SYNC_BYTE)) begin
               state_s = ST_ADDR;
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_ADDR: begin
            if (byte_stb_s) begin
               addr_sh_s  = din;
               byte_cnt_s = 3'd0;
               state_s    = ST_DATA;
            end else if (tmo_hit_s) begin
               state_s     = ST_IDLE;
               frame_err_s = 1'b1;
            end else begin
               state_s = ST_ADDR;
            end
         end
         ST_DATA: begin
            if (byte_stb_s) begin
               data_sh_s  = DW'({data_sh_r, din});
               byte_cnt_s = byte_cnt_r + 3'd1;
               if (byte_cnt_r == LAST_BYTE) begin
`ifdef UART_CMD_CHECKSUM_EN
                  state_s = ST_CHK;
`else
                  state_s = ST_WRITE;
`endif
               end else begin
                  state_s = ST_DATA;
               end
            end else if (tmo_hit_s) begin
               state_s     = ST_IDLE;
               frame_err_s = 1'b1;
            end else begin
               state_s = ST_DATA;
            end
         end
`ifdef UART_CMD_CHECKSUM_EN
         ST_CHK: begin
            if (byte_stb_s) begin
               if (din == cmd_xor(addr_sh_r, 32'(data_sh_r))) begin
                  state_s = ST_WRITE;
               end else begin
                  state_s     = ST_IDLE;
                  frame_err_s = 1'b1;
               end
            end else if (tmo_hit_s) begin
               state_s     = ST_IDLE;
               frame_err_s = 1'b1;
            end else begin
               state_s = ST_CHK;
            end
         end
`endif
         ST_WRITE: begin
            // Any byte arriving during the strobe cycle is dropped.
            state_s = ST_IDLE;
         end
         default: begin
            state_s = ST_IDLE;
         end
      endcase

      if (byte_stb_s || (state_r == ST_IDLE) || tmo_hit_s) begin
         tmo_cnt_s = {TW{1'b0}};
      end else begin
         tmo_cnt_s = tmo_cnt_r + {{(TW-1){1'b0}}, 1'b1};
      end

      wr_en_s = (state_s == ST_WRITE);
      busy_s  = (state_s != ST_IDLE);
      if (wr_en_s) begin
         wr_addr_s = addr_sh_s;
         wr_data_s = data_sh_s;
      end else begin
         wr_addr_s = wr_addr;
         wr_data_s = wr_data;
      end
   end

   // State, shadow, counter and output registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r    <= ST_IDLE;
         addr_sh_r  <= 8'h00;
         data_sh_r  <= {DW{1'b0}};
         byte_cnt_r <= 3'd0;
         tmo_cnt_r  <= {TW{1'b0}};
         wr_en      <= 1'b0;
         wr_addr    <= 8'h00;
         wr_data    <= {DW{1'b0}};
         frame_err  <= 1'b0;
         busy       <= 1'b0;
      end else begin
         state_r    <= state_s;
         addr_sh_r  <= addr_sh_s;
         data_sh_r  <= data_sh_s;
         byte_cnt_r <= byte_cnt_s;
         tmo_cnt_r  <= tmo_cnt_s;
         wr_en      <= wr_en_s;
         wr_addr    <= wr_addr_s;
         wr_data    <= wr_data_s;
         frame_err  <= frame_err_s;
         busy       <= busy_s;
      end
   end

endmodule
